// File: rtl/led_pattern_checker_if.sv
// Signal bundle between the running-light checker and its host.
// master drives the LED bus and clear, slave reports status.
interface led_pattern_checker_if;
  logic        clr;
  logic [9:0]  runled;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic [3:0]  pos;

  modport master (
    output clr, runled,
    input  locked, err, err_cnt, pos
  );

  modport slave (
    input  clr, runled,
    output locked, err, err_cnt, pos
  );
endinterface

// File: rtl/led_pattern_checker.sv
// Running-light self-test monitor: one-hot, rotate-left, step interval.
// Optional stall detection in TRACK: define LEDCHK_TIMEOUT_EN.
module led_pattern_checker #(
  parameter logic [19:0] DECIMATION = 20'd1000000,
  parameter logic [19:0] TOL        = 20'd2,
  parameter logic [3:0]  LOCK_STEPS = 4'd3
) (
  input  logic                  clk,
  input  logic                  reset,
  led_pattern_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    TRACK
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  s0_q, s1_q;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  sync_q, sync_d;
  logic        exempt_q, exempt_d;
  logic [3:0]  pos_q, pos_d;
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        step, onehot, rot_ok, ival_ok, good;
  logic [20:0] ival, ival_lo, ival_hi;
  logic [3:0]  idx;

  // Sampling pipeline keeps running through reset so IDLE sees filled taps.
  always_ff @(posedge clk) begin
    s0_q <= bus.runled;
    s1_q <= s0_q;
  end

  assign step    = (s0_q != s1_q);
  assign onehot  = (s0_q != '0) &&
                   ((s0_q & (s0_q - 10'd1)) == '0);
  assign rot_ok  = (s0_q == {s1_q[8:0], s1_q[9]});
  assign ival    = {1'b0, cnt_q} + 21'd1;
  assign ival_lo = {1'b0, DECIMATION} - {1'b0, TOL};
  assign ival_hi = {1'b0, DECIMATION} + {1'b0, TOL};
  assign ival_ok = (ival >= ival_lo) && (ival <= ival_hi);
  assign good    = onehot && rot_ok && (exempt_q || ival_ok);

  always_comb begin
    idx = 4'd15;
    for (int i = 0; i < 10; i++) begin
      if (s0_q[i]) idx = 4'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    sync_d   = sync_q;
    exempt_d = exempt_q;
    pos_d    = pos_q;
    err_d    = 1'b0;
    cnt_d    = step ? '0 :
               (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;
    unique case (state_q)
      IDLE: begin
        state_d  = SYNC;
        sync_d   = '0;
        exempt_d = 1'b1;
      end
      SYNC: begin
        if (step) begin
          pos_d = onehot ? idx : 4'd15;
          if (good) begin
            exempt_d = 1'b0;
            if (sync_q + 4'd1 >= LOCK_STEPS) begin
              state_d = TRACK;
              sync_d  = '0;
            end else begin
              sync_d = sync_q + 4'd1;
            end
          end else begin
            sync_d   = '0;
            exempt_d = 1'b1;
          end
        end
      end
      TRACK: begin
        if (step) begin
          pos_d = onehot ? idx : 4'd15;
          if (good) begin
            exempt_d = 1'b0;
          end else begin
            err_d    = 1'b1;
            state_d  = SYNC;
            sync_d   = '0;
            exempt_d = 1'b1;
          end
        end
`ifdef LEDCHK_TIMEOUT_EN
        // Leaving TRACK guarantees a single stall error per stall.
        else if (cnt_q == DECIMATION + TOL + 20'd1) begin
          err_d    = 1'b1;
          state_d  = SYNC;
          sync_d   = '0;
          exempt_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.clr)
      err_cnt_d = '0;
    else if (err_d && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sync_q    <= '0;
      exempt_q  <= 1'b1;
      pos_q     <= 4'd15;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      exempt_q  <= exempt_d;
      pos_q     <= pos_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.locked  = (state_q == TRACK);
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.pos     = pos_q;

endmodule
